// File: rtl/core_boot_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// core_boot_sequencer_pkg
// Shared definitions for the boot sequencer slice.
//   - FSM state encodings ST_IDLE..ST_ERROR.
//     ST_ERROR is only reachable when BOOT_CHECKSUM_EN is defined.
//   - depth_of(): derives the imem depth (2**IMW words) from the address width.
// ---------------------------------------------------------------------------
package core_boot_sequencer_pkg;

    localparam int ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_LOAD  = 3'd1;
    localparam logic [ST_W-1:0] ST_START = 3'd2;
    localparam logic [ST_W-1:0] ST_RUN   = 3'd3;
    localparam logic [ST_W-1:0] ST_DONE  = 3'd4;
    localparam logic [ST_W-1:0] ST_ERROR = 3'd5;

    function automatic int unsigned depth_of(input int unsigned imw);
        return 32'd1 << imw;
    endfunction

endpackage

// File: rtl/core_boot_sequencer_if.sv
// ---------------------------------------------------------------------------
// core_boot_sequencer_if
// Bundles the program stream, the Core imem write port and the Core control
// lines that the sequencer drives or observes.
//
// Handshake: a program word transfers on every rising clk edge where
// in_valid and in_ready are both high.
//   - The source holds in_data stable while in_valid is high and no transfer
//     has happened.
//   - in_ready does not depend on in_valid.
//
//   master (sequencer): in  in_valid, in_data, core_halt, core_result
//                       out in_ready, imem_we, imem_addr, imem_wdata,
//                           core_start, core_run
//   slave  (environment): the mirror image
// ---------------------------------------------------------------------------
interface core_boot_sequencer_if #(
    parameter int DW  = 8,
    parameter int IW  = 8,
    parameter int IMW = 4
) ();
    logic           in_valid;
    logic [IW-1:0]  in_data;
    logic           in_ready;
    logic           imem_we;
    logic [IMW-1:0] imem_addr;
    logic [IW-1:0]  imem_wdata;
    logic           core_start;
    logic           core_run;
    logic           core_halt;
    logic [DW-1:0]  core_result;

    modport master (
        input  in_valid, in_data, core_halt, core_result,
        output in_ready, imem_we, imem_addr, imem_wdata, core_start, core_run
    );

    modport slave (
        output in_valid, in_data, core_halt, core_result,
        input  in_ready, imem_we, imem_addr, imem_wdata, core_start, core_run
    );
endinterface

// File: rtl/core_boot_sequencer_watchdog.sv
// ---------------------------------------------------------------------------
// boot_run_watchdog
// Counts run cycles and decides how a run ends.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   clear        zero the counter (new sequence or START cycle)
//   run          the sequencer is in RUN
//   hold         freeze the counter this cycle (abort)
//   core_halt    halt indication from the Core
//   cycle_count  run cycles elapsed
//   halt_ev      the run ends on halt this cycle
//   limit_ev     the run ends on the cycle limit this cycle
//
// The counter shows 0 in the first RUN cycle and advances on every RUN
// cycle, including the final one. Its value after a run therefore equals
// the number of RUN cycles spent.
// ---------------------------------------------------------------------------
module boot_run_watchdog #(
    parameter int CW          = 16,
    parameter int CYCLE_LIMIT = 1000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          run,
    input  logic          hold,
    input  logic          core_halt,
    output logic [CW-1:0] cycle_count,
    output logic          halt_ev,
    output logic          limit_ev
);
    localparam logic [CW-1:0] LAST = CW'(CYCLE_LIMIT - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
        end else if (clear) begin
            cycle_count <= '0;
        end else if (run && !hold) begin
            cycle_count <= cycle_count + 1'b1;
        end
    end

    // Halt takes priority over the limit when both occur in the same cycle.
    assign halt_ev  = run && core_halt;
    assign limit_ev = run && !core_halt && (cycle_count == LAST);
endmodule

// File: rtl/core_boot_sequencer.sv
// ---------------------------------------------------------------------------
// core_boot_sequencer
// Streams a program into Core imem, then starts the Core and supervises the
// run until it halts, times out or is aborted.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   go              start a load/run sequence (accepted in IDLE/DONE/ERROR)
//   abort           cancel from LOAD/START/RUN
//   load_len        words to load; 0 runs the existing imem contents
//   bus             core_boot_sequencer_if.master: program stream, imem
//                   write port, core_start/core_run/core_halt/core_result
//   result_data     core_result captured on halt
//   cycle_count     run cycles elapsed
//   done, timeout   sticky run-end flags
//   busy            in LOAD, START or RUN
//   dbg_state       current FSM state
//
// Optional feature (macro BOOT_CHECKSUM_EN):
//   - Adds expect_sum (sampled with go) and sum_err.
//   - A load whose mod-2**IW word sum differs from expect_sum ends in ERROR
//     instead of starting the Core.
// ---------------------------------------------------------------------------
module core_boot_sequencer
    import core_boot_sequencer_pkg::*;
#(
    parameter int DW          = 8,
    parameter int IW          = 8,
    parameter int IMW         = 4,
    parameter int CW          = 16,
    parameter int CYCLE_LIMIT = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 abort,
    input  logic [IMW:0]         load_len,
`ifdef BOOT_CHECKSUM_EN
    input  logic [IW-1:0]        expect_sum,
    output logic                 sum_err,
`endif
    core_boot_sequencer_if.master bus,
    output logic [DW-1:0]        result_data,
    output logic [CW-1:0]        cycle_count,
    output logic                 done,
    output logic                 timeout,
    output logic                 busy,
    output logic [ST_W-1:0]      dbg_state
);
    localparam logic [IMW:0] DEPTH_L = (IMW+1)'(depth_of(IMW));

    logic [ST_W-1:0] state;
    logic [IMW:0]    len;
    logic [IMW:0]    wr_idx;
    logic [IMW:0]    len_sel;
    logic            go_ok;
    logic            accept;
    logic            last_word;
    logic            halt_ev;
    logic            limit_ev;

    assign len_sel   = (load_len > DEPTH_L) ? DEPTH_L : load_len;
    assign go_ok     = go && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
    // abort blocks the write in the cycle it is asserted.
    assign accept    = (state == ST_LOAD) && bus.in_valid && !abort;
    assign last_word = accept && (wr_idx == len - (IMW+1)'(1));

    assign bus.in_ready   = (state == ST_LOAD);
    assign bus.imem_we    = accept;
    assign bus.imem_addr  = wr_idx[IMW-1:0];
    assign bus.imem_wdata = bus.in_data;
    assign bus.core_start = (state == ST_START);
    assign bus.core_run   = (state == ST_START) || (state == ST_RUN);
    assign busy           = (state == ST_LOAD) || (state == ST_START) || (state == ST_RUN);
    assign dbg_state      = state;

`ifdef BOOT_CHECKSUM_EN
    logic [IW-1:0] sum;
    logic [IW-1:0] sum_exp;
    logic [IW-1:0] sum_next;
    assign sum_next = sum + bus.in_data;
`endif

    boot_run_watchdog #(
        .CW          (CW),
        .CYCLE_LIMIT (CYCLE_LIMIT)
    ) u_watchdog (
        .clk         (clk),
        .rst         (rst),
        .clear       (go_ok || state == ST_START),
        .run         (state == ST_RUN),
        .hold        (abort),
        .core_halt   (bus.core_halt),
        .cycle_count (cycle_count),
        .halt_ev     (halt_ev),
        .limit_ev    (limit_ev)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            len         <= '0;
            wr_idx      <= '0;
            result_data <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            sum         <= '0;
            sum_exp     <= '0;
            sum_err     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (go) begin
                        len         <= len_sel;
                        wr_idx      <= '0;
                        result_data <= '0;
                        done        <= 1'b0;
                        timeout     <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
                        sum         <= '0;
                        sum_exp     <= expect_sum;
                        sum_err     <= 1'b0;
`endif
                        state       <= (len_sel != '0) ? ST_LOAD : ST_START;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (accept) begin
                        wr_idx <= wr_idx + 1'b1;
`ifdef BOOT_CHECKSUM_EN
                        sum    <= sum_next;
                        if (last_word) begin
                            if (sum_next == sum_exp) begin
                                state <= ST_START;
                            end else begin
                                state   <= ST_ERROR;
                                sum_err <= 1'b1;
                            end
                        end
`else
                        if (last_word) begin
                            state <= ST_START;
                        end
`endif
                    end
                end
                ST_START: begin
                    state <= abort ? ST_IDLE : ST_RUN;
                end
                ST_RUN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (halt_ev) begin
                        result_data <= bus.core_result;
                        done        <= 1'b1;
                        state       <= ST_DONE;
                    end else if (limit_ev) begin
                        timeout <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
